// File: rtl/pe64_request_scheduler_if.sv
// Bundle of the scheduler's request-side and grant-side signals.
// master : the request sources / service unit side (drives req, mask, flush,
//          grant_ready, done; observes the grant and status outputs).
// slave  : the scheduler itself.
// CNT_W sets the width of grant_count and must match the scheduler's CNT_W.
interface pe64_request_scheduler_if #(
    parameter int CNT_W = 16
);
    logic [63:0]      req;
    logic [63:0]      mask;
    logic             flush;
    logic             grant_ready;
    logic             done;
    logic             grant_valid;
    logic [5:0]       grant_idx;
    logic             busy;
    logic [63:0]      pending;
    logic             any_pending;
    logic [CNT_W-1:0] grant_count;

    modport master (
        output req, mask, flush, grant_ready, done,
        input  grant_valid, grant_idx, busy, pending, any_pending, grant_count
    );

    modport slave (
        input  req, mask, flush, grant_ready, done,
        output grant_valid, grant_idx, busy, pending, any_pending, grant_count
    );
endinterface

// File: rtl/pe64_request_scheduler.sv
// 64-way request scheduler.
// Request pulses are latched into a sticky pending vector; eligible requests
// (pending & mask) are arbitrated highest-index-first, one grant at a time,
// over a valid/ready handshake. With WAIT_DONE=1 the scheduler then holds the
// shared resource until done; with WAIT_DONE=0 it returns to IDLE at once.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave modport: req/mask/flush/grant_ready/done in;
//           grant_valid/grant_idx/busy/pending/any_pending/grant_count out
module pe64_request_scheduler #(
    parameter bit WAIT_DONE = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pe64_request_scheduler_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [63:0]      pending_reg, pending_next;
    logic [5:0]       grant_idx_reg, grant_idx_next;
    logic             grant_valid_reg;
    logic [CNT_W-1:0] grant_count_reg;

    logic [63:0]      eligible;
    logic [63:0]      clr;
    logic [5:0]       enc_idx;
    logic             any_pending;
    logic             handshake;

    assign eligible    = pending_reg & bus.mask;
    assign any_pending = |eligible;

    // Priority encoder: later iterations overwrite earlier ones, so the
    // highest set index wins. Empty vector yields 0 (qualified by any_pending).
    always_comb begin
        enc_idx = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (eligible[i]) begin
                enc_idx = 6'(i);
            end
        end
    end

    // One-hot clear of the granted requester, only on a completed handshake.
    for (genvar gi = 0; gi < 64; gi++) begin : g_clr
        assign clr[gi] = handshake && (grant_idx_reg == 6'(gi));
    end

    // Next-state logic. flush overrides everything and suppresses the
    // handshake so no grant completes in a flush cycle.
    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        handshake      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_pending) begin
                    grant_idx_next = enc_idx;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (bus.grant_ready) begin
                    handshake  = 1'b1;
                    state_next = WAIT_DONE ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                if (bus.done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (bus.flush) begin
            state_next     = IDLE;
            grant_idx_next = grant_idx_reg;
            handshake      = 1'b0;
        end
    end

    // Set wins over the handshake clear; flush discards same-cycle requests.
    always_comb begin
        pending_next = bus.req | (pending_reg & ~clr);
        if (bus.flush) begin
            pending_next = 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pending_reg     <= 64'd0;
            grant_idx_reg   <= 6'd0;
            grant_valid_reg <= 1'b0;
            grant_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            grant_idx_reg   <= grant_idx_next;
            // Registered copy of "next state is GRANT" so grant_valid comes
            // straight from a flop.
            grant_valid_reg <= (state_next == GRANT);
            if (handshake) begin
                grant_count_reg <= grant_count_reg + 1'b1;
            end
        end
    end

    assign bus.grant_valid = grant_valid_reg;
    assign bus.grant_idx   = grant_idx_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.pending     = pending_reg;
    assign bus.any_pending = any_pending;
    assign bus.grant_count = grant_count_reg;
endmodule

// File: tb/tb_pe64_request_scheduler.sv
// Directed bench: u0 runs with WAIT_DONE=1, CNT_W=16; u1 with WAIT_DONE=0,
// CNT_W=2 for back-to-back grants and counter wrap.
module tb_pe64_request_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pe64_request_scheduler_if #(.CNT_W(16)) b0 ();
    pe64_request_scheduler_if #(.CNT_W(2))  b1 ();

    pe64_request_scheduler #(.WAIT_DONE(1'b1), .CNT_W(16)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    pe64_request_scheduler #(.WAIT_DONE(1'b0), .CNT_W(2)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Wait (bounded) for grant_valid on u0.
    task automatic wait_grant(input string tag);
        int n = 0;
        while (b0.grant_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(b0.grant_valid), 64'd1);
    endtask

    // Wait for a grant, check its index, accept it, then pulse done.
    task automatic serve(input int exp_idx, input string tag);
        wait_grant(tag);
        check({tag, "_idx"}, 64'(b0.grant_idx), 64'(exp_idx));
        b0.grant_ready = 1'b1;
        step();
        b0.grant_ready = 1'b0;
        check({tag, "_svc_busy"}, 64'(b0.busy), 64'd1);
        check({tag, "_svc_gv"}, 64'(b0.grant_valid), 64'd0);
        b0.done = 1'b1;
        step();
        b0.done = 1'b0;
        check({tag, "_idle_busy"}, 64'(b0.busy), 64'd0);
    endtask

    task automatic pulse_req(input logic [63:0] bits);
        b0.req = bits;
        step();
        b0.req = 64'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        b0.req = '1; b0.mask = '1; b0.flush = 1'b0; b0.grant_ready = 1'b0; b0.done = 1'b0;
        b1.req = '1; b1.mask = '1; b1.flush = 1'b0; b1.grant_ready = 1'b0; b1.done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        b0.req = 64'd0;
        b1.req = 64'd0;

        // Reset state
        check("rst_gv",      64'(b0.grant_valid), 64'd0);
        check("rst_idx",     64'(b0.grant_idx),   64'd0);
        check("rst_busy",    64'(b0.busy),        64'd0);
        check("rst_pending", b0.pending,          64'd0);
        check("rst_anyp",    64'(b0.any_pending), 64'd0);
        check("rst_count",   64'(b0.grant_count), 64'd0);
        check("rst_count1",  64'(b1.grant_count), 64'd0);
        step();
        check("rst_pending2", b0.pending, 64'd0);
        check("rst_gv2",      64'(b0.grant_valid), 64'd0);

        // Priority: 63, 40, 3 in one cycle
        pulse_req((64'd1 << 63) | (64'd1 << 40) | (64'd1 << 3));
        check("prio_pending", b0.pending, (64'd1 << 63) | (64'd1 << 40) | (64'd1 << 3));
        check("prio_latency_gv", 64'(b0.grant_valid), 64'd0);
        step();
        check("prio_latency_gv2", 64'(b0.grant_valid), 64'd1);
        serve(63, "prio63");
        serve(40, "prio40");
        serve(3,  "prio3");
        check("prio_count",   64'(b0.grant_count), 64'd3);
        check("prio_pending0", b0.pending, 64'd0);

        // Frozen grant: 5 granted, 60 arrives while stalled
        pulse_req(64'd1 << 5);
        wait_grant("frz5");
        check("frz5_idx", 64'(b0.grant_idx), 64'd5);
        pulse_req(64'd1 << 60);
        step();
        step();
        check("frz_gv",      64'(b0.grant_valid), 64'd1);
        check("frz_idx",     64'(b0.grant_idx),   64'd5);
        check("frz_pending", b0.pending, (64'd1 << 60) | (64'd1 << 5));
        serve(5,  "frz_a");
        serve(60, "frz_b");
        check("frz_count", 64'(b0.grant_count), 64'd5);

        // Mask: 60 retained but not granted while masked
        b0.mask = ~(64'd1 << 60);
        pulse_req(64'd1 << 60);
        step(); step(); step(); step();
        check("mask_gv",      64'(b0.grant_valid), 64'd0);
        check("mask_busy",    64'(b0.busy),        64'd0);
        check("mask_pending", b0.pending,          64'd1 << 60);
        check("mask_anyp",    64'(b0.any_pending), 64'd0);
        b0.mask = '1;
        #1;
        check("mask_anyp_on", 64'(b0.any_pending), 64'd1);
        serve(60, "mask60");
        check("mask_count", 64'(b0.grant_count), 64'd6);

        // Set-wins: req[7] in the handshake cycle for 7
        pulse_req(64'd1 << 7);
        wait_grant("sw7");
        check("sw7_idx", 64'(b0.grant_idx), 64'd7);
        b0.grant_ready = 1'b1;
        b0.req = 64'd1 << 7;
        step();
        b0.grant_ready = 1'b0;
        b0.req = 64'd0;
        check("sw_pending", b0.pending, 64'd1 << 7);
        check("sw_count",   64'(b0.grant_count), 64'd7);
        b0.done = 1'b1;
        step();
        b0.done = 1'b0;
        serve(7, "sw7_again");
        check("sw_count2",   64'(b0.grant_count), 64'd8);
        check("sw_pending0", b0.pending, 64'd0);

        // Flush during GRANT with grant_ready=1 and a same-cycle req
        pulse_req(64'd1 << 20);
        wait_grant("fl20");
        b0.grant_ready = 1'b1;
        b0.flush = 1'b1;
        b0.req = 64'd1 << 9;
        step();
        b0.grant_ready = 1'b0;
        b0.flush = 1'b0;
        b0.req = 64'd0;
        check("fl_gv",      64'(b0.grant_valid), 64'd0);
        check("fl_busy",    64'(b0.busy),        64'd0);
        check("fl_count",   64'(b0.grant_count), 64'd8);
        check("fl_pending", b0.pending,          64'd0);
        step(); step();
        check("fl_gv_later", 64'(b0.grant_valid), 64'd0);

        // Stray done in IDLE, then in GRANT
        b0.done = 1'b1;
        step();
        b0.done = 1'b0;
        check("sd_idle_busy",  64'(b0.busy),        64'd0);
        check("sd_idle_count", 64'(b0.grant_count), 64'd8);
        pulse_req(64'd1 << 11);
        wait_grant("sd11");
        b0.done = 1'b1;
        step();
        b0.done = 1'b0;
        check("sd_grant_gv",  64'(b0.grant_valid), 64'd1);
        check("sd_grant_idx", 64'(b0.grant_idx),   64'd11);
        check("sd_grant_busy", 64'(b0.busy),       64'd1);
        check("sd_grant_count", 64'(b0.grant_count), 64'd8);
        serve(11, "sd11_serve");
        check("sd_count", 64'(b0.grant_count), 64'd9);

        // WAIT_DONE=0, CNT_W=2: five back-to-back grants, count wraps to 1
        b1.req = 64'h1f;
        b1.grant_ready = 1'b1;
        step();
        b1.req = 64'd0;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("b2b%0d_gv", k),  64'(b1.grant_valid), 64'd1);
            check($sformatf("b2b%0d_idx", k), 64'(b1.grant_idx),   64'(4 - k));
            step();
            check($sformatf("b2b%0d_gap", k),   64'(b1.grant_valid), 64'd0);
            check($sformatf("b2b%0d_count", k), 64'(b1.grant_count), 64'((k + 1) % 4));
            step();
        end
        b1.grant_ready = 1'b0;
        check("wrap_count",   64'(b1.grant_count), 64'd1);
        check("wrap_pending", b1.pending,          64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe64_request_scheduler.md
# pe64_request_scheduler

Sequential arbiter built around the team's 64-input priority encoder. It latches single-cycle request pulses from 64 requesters into a sticky pending vector and masks them. Each round it selects the highest-index eligible requester, issues one grant at a time over a valid/ready handshake, and holds the shared resource until the requester signals completion. It sits between the 64 request sources and the single shared service unit.

## Interface
- WAIT_DONE, 1: 1 = hold in SERVICE until `done`; 0 = return to IDLE directly after the grant handshake
- CNT_W, 16: width of the grant counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  64  request pulses; bit i sets pending[i]
- mask  in  64  enable per requester; 0 = not eligible; pending bit still retained
- flush  in  1  synchronous clear of all pending bits and abort of the current round
- grant_ready  in  1  service unit accepts the grant
- done  in  1  service unit finished the granted request
- grant_valid  out  1  grant offered
- grant_idx  out  6  index of granted requester, bit 5 = MSB
- busy  out  1  high in GRANT and SERVICE
- pending  out  64  registered pending vector
- any_pending  out  1  OR of (pending & mask), combinational from registers
- grant_count  out  CNT_W  number of completed grant handshakes, wraps

## Operation
- Reset (rst_n=0 at an edge) has priority over everything. It forces state=IDLE, pending=0, grant_valid=0, grant_idx=0, busy=0, grant_count=0.
- Pending update each edge:
  - pending[i] <= req[i] | (pending[i] & ~clr[i]).
  - clr is one-hot at grant_idx on a grant handshake, otherwise 0.
  - Set wins: req[i] in the handshake cycle keeps pending[i]=1.
- Eligible vector is pending & mask. The encoder returns the highest set index, with 63 highest priority. When no bit is set it returns 0, qualified by any_pending.
- FSM states:
  - IDLE: if any_pending, register grant_idx = encoder output and go to GRANT. Otherwise stay in IDLE.
  - GRANT: grant_valid=1. grant_idx is frozen; later higher-priority requests or mask changes do not alter or withdraw it. On grant_ready, clear pending[grant_idx], increment grant_count, and go to SERVICE (WAIT_DONE=1) or IDLE (WAIT_DONE=0).
  - SERVICE: grant_valid=0, busy=1. On done, go to IDLE.
- `done` is ignored outside SERVICE. `grant_ready` is ignored outside GRANT.
- flush (rst_n=1):
  - Clears pending to 0 and forces IDLE with grant_valid=0. `req` bits in the same cycle are also discarded.
  - A flush during GRANT withdraws the grant; this is the only allowed withdrawal. No handshake completes and grant_count is not incremented, even if grant_ready=1.
  - A flush during SERVICE abandons the wait for done.
- grant_count wraps from 2^CNT_W−1 to 0.
- grant_idx keeps its last value outside GRANT.

## Timing
- Request-to-grant latency, idle scheduler:
  - req[i] in cycle 0 sets pending[i] at the end of cycle 0.
  - IDLE evaluates in cycle 1.
  - grant_valid=1 with grant_idx=i in cycle 2.
- Handshake in cycle k: pending bit cleared and count updated at the end of cycle k. grant_valid=0 from cycle k+1.
- WAIT_DONE=1: done in cycle m returns to IDLE at the end of m. The next grant_valid appears in cycle m+2 at the earliest.
- WAIT_DONE=0: back-to-back grants are possible, one every 2 cycles with grant_ready held high.
- grant_valid and grant_idx are registered outputs. The only combinational outputs are busy (decoded from state) and any_pending.

## Test plan
- Reset: drive rst_n=0 with req=all-ones for 2 cycles -> every output is 0 after release; pending=0.
- Priority: pulse req bits 3, 40 and 63 in the same cycle; grant_ready=1, WAIT_DONE=1, done one cycle after each grant -> grants issued in order 63, 40, 3; grant_count=3; pending=0.
- Frozen grant and mask:
  - req[5] granted, then req[60] arrives while in GRANT with grant_ready=0 -> grant_idx stays 5 until accepted; 60 is granted next.
  - With mask[60]=0, 60 stays pending and is not granted until the mask is set.
- Set-wins: req[7] asserted in the same cycle as the handshake for index 7 -> pending[7]=1 afterward; 7 is granted again.
- Flush: flush during GRANT with grant_ready=1 -> grant_valid=0 next cycle; grant_count unchanged; pending=0; state IDLE.
- Wrap and stray done:
  - With CNT_W=2, perform 5 grants -> grant_count=1.
  - done pulses in IDLE and GRANT have no effect.
